// File: rtl/sa_result_drain_if.sv
// sa_result_drain_if -- bundle between the result-drain block and its host.
//   init, base_address_C     : start pulse and address of C[0][0]
//   res_valid/res_data/res_ready : one accumulator row from the systolic array
//   mem_we/mem_addr/mem_wdata    : one-word-per-cycle memory write port
//   complete                 : whole N x N matrix has been written
// master = host/array/memory side, slave = the drain block.
interface sa_result_drain_if #(
    parameter int N     = 5,
    parameter int ACC_W = 16,
    parameter int DW    = 8,
    parameter int AW    = 8
);
    logic                 init;
    logic [AW-1:0]        base_address_C;
    logic                 res_valid;
    logic [N*ACC_W-1:0]   res_data;
    logic                 res_ready;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 complete;

    modport master (
        output init, base_address_C, res_valid, res_data,
        input  res_ready, mem_we, mem_addr, mem_wdata, complete
    );

    modport slave (
        input  init, base_address_C, res_valid, res_data,
        output res_ready, mem_we, mem_addr, mem_wdata, complete
    );
endinterface

// File: rtl/sa_result_drain.sv
// sa_result_drain -- drains an N x N systolic-array result matrix to memory.
// Each accepted row of N signed accumulators is written as N consecutive
// words at base + row*N + col (mod 2^AW), row-major, then 'complete' is held
// until the next init.
// Ports: clk, rst (synchronous, active-high), bus (sa_result_drain_if.slave).
// Build option: define SA_DRAIN_SATURATE_EN to clamp each accumulator to the
// signed DW-bit range before writing; otherwise the low DW bits are written.
module sa_result_drain #(
    parameter int N     = 5,
    parameter int ACC_W = 16,
    parameter int DW    = 8,
    parameter int AW    = 8
) (
    input logic               clk,
    input logic               rst,
    sa_result_drain_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(N - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
    localparam logic [AW-1:0] N_A      = AW'(N);

    typedef enum logic [1:0] {IDLE, WAIT_ROW, WRITE, DONE} state_t;

    state_t                    state, state_nxt;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic [AW-1:0]             base;
    logic [N-1:0][ACC_W-1:0]   row_buf;
    logic signed [ACC_W-1:0]   acc;
    logic [DW-1:0]             wdata;
    logic [AW-1:0]             addr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row     <= '0;
            col     <= '0;
            base    <= '0;
            row_buf <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.init) begin
                    base <= bus.base_address_C;
                    row  <= '0;
                    col  <= '0;
                end
                WAIT_ROW: if (bus.res_valid) begin
                    row_buf <= bus.res_data;
                    col     <= '0;
                end
                WRITE: begin
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address arithmetic is done in AW bits so it wraps naturally.
    assign addr = base + AW'(row) * N_A + AW'(col);
    assign acc  = row_buf[col];

`ifdef SA_DRAIN_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (DW - 1)));
    always_comb begin
        wdata = acc[DW-1:0];
        if (acc > SAT_HI)      wdata = SAT_HI[DW-1:0];
        else if (acc < SAT_LO) wdata = SAT_LO[DW-1:0];
    end
`else
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc[ACC_W-1:DW];
    assign wdata = acc[DW-1:0];
`endif

    always_comb begin
        state_nxt     = state;
        bus.res_ready = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.complete  = 1'b0;
        case (state)
            IDLE: if (bus.init) state_nxt = WAIT_ROW;
            WAIT_ROW: begin
                bus.res_ready = 1'b1;
                if (bus.res_valid) state_nxt = WRITE;
            end
            WRITE: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr;
                bus.mem_wdata = wdata;
                if (col == LAST_COL)
                    state_nxt = (row == LAST_ROW) ? DONE : WAIT_ROW;
            end
            DONE: begin
                bus.complete = 1'b1;
                if (bus.init) state_nxt = WAIT_ROW;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: stimulus pushes expected {addr,data}
// words; a negedge monitor pops and compares on every mem_we.
module tb_sa_result_drain;
    localparam int N = 5, ACC_W = 16, DW = 8, AW = 8;

    typedef logic [N-1:0][ACC_W-1:0] row_t;
    typedef logic [N-1:0][DW-1:0]    erow_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sa_result_drain_if #(.N(N), .ACC_W(ACC_W), .DW(DW), .AW(AW)) bus ();
    sa_result_drain #(.N(N), .ACC_W(ACC_W), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    bit mon_en = 1'b0;
    logic [AW+DW-1:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard; idle bus must be zero.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (mon_en) begin
            if (bus.mem_we === 1'b1) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(e[AW+DW-1:DW]));
                    chk("wr_data", 32'(bus.mem_wdata), 32'(e[DW-1:0]));
                end
            end else begin
                chk("idle_bus_zero", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic row_t seq_row(input int r, input int off);
        row_t v;
        for (int j = 0; j < N; j++) v[j] = ACC_W'(off + r * N + j + 1);
        return v;
    endfunction

    function automatic erow_t seq_exp(input int r, input int off);
        erow_t v;
        for (int j = 0; j < N; j++) v[j] = DW'(off + r * N + j + 1);
        return v;
    endfunction

    task automatic push_row(input int base, input int r, input erow_t e);
        for (int j = 0; j < N; j++) sb.push_back({AW'(base + r * N + j), e[j]});
    endtask

    task automatic do_init(input int b);
        bus.base_address_C = AW'(b);
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
    endtask

    // Presents a row and returns one cycle after it was captured (state WRITE).
    task automatic send_row(input row_t d);
        int t = 0;
        bus.res_data  = d;
        bus.res_valid = 1'b1;
        while (bus.res_ready !== 1'b1 && t < 100) begin tick(); t++; end
        if (bus.res_ready !== 1'b1) chk("row_accept_timeout", 32'(bus.res_ready), 32'd1);
        tick();
        bus.res_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (bus.complete !== 1'b1 && t < 200) begin tick(); t++; end
        chk("complete_set", 32'(bus.complete), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_rows(input int base, input int off, input int gap);
        for (int r = 0; r < N; r++) begin
            push_row(base, r, seq_exp(r, off));
            send_row(seq_row(r, off));
            repeat (gap) tick();
        end
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, w1, t, rdy_cnt, r;
        bit cap;
        row_t  sat_d;
        erow_t sat_e;

        // Reset wins over init/res_valid asserted alongside it.
        rst = 1'b1;
        bus.init = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_data = '1;
        bus.base_address_C = '1;
        repeat (3) tick();
        chk("rst_res_ready", 32'(bus.res_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_complete", 32'(bus.complete), 32'd0);
        rst = 1'b0;
        bus.init = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data = '0;
        bus.base_address_C = '0;
        tick();
        chk("idle_no_ready", 32'(bus.res_ready), 32'd0);
        mon_en = 1'b1;

        // Paced rows, base 50 -> addr 50..74, data 1..25.
        do_init(50);
        run_rows(50, 0, 6);

        // res_valid held high: one ready cycle per row, rows change after capture.
        do_init(0);
        w0 = wr_cnt;
        rdy_cnt = 0;
        r = 0;
        cap = 1'b0;
        t = 0;
        bus.res_data = seq_row(0, 100);
        bus.res_valid = 1'b1;
        while (bus.complete !== 1'b1 && t < 300) begin
            if (bus.res_ready === 1'b1) begin
                push_row(0, r, seq_exp(r, 100));
                rdy_cnt++;
                r++;
                cap = 1'b1;
            end else if (cap) begin
                bus.res_data = seq_row(r, 100);
                cap = 1'b0;
            end
            tick();
            t++;
        end
        bus.res_valid = 1'b0;
        chk("held_ready_cycles", 32'(rdy_cnt), 32'd5);
        chk("held_write_count", 32'(wr_cnt - w0), 32'd25);
        chk("held_complete", 32'(bus.complete), 32'd1);
        chk("held_sb_drained", 32'(sb.size()), 32'd0);

        // Address wrap: 250..255 then 0..18.
        do_init(250);
        run_rows(250, 40, 0);

        // Saturation / truncation of out-of-range accumulators.
        do_init(0);
        sat_d[0] = 16'd300;
        sat_d[1] = 16'hFF38;
        sat_d[2] = 16'd127;
        sat_d[3] = 16'hFF80;
        sat_d[4] = 16'h0105;
`ifdef SA_DRAIN_SATURATE_EN
        sat_e = {8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F};
`else
        sat_e = {8'h05, 8'h80, 8'h7F, 8'h38, 8'h2C};
`endif
        push_row(0, 0, sat_e);
        send_row(sat_d);
        for (int k = 1; k < N; k++) begin
            push_row(0, k, '0);
            send_row('0);
        end
        wait_done();

        // Reset after 3rd write of row 2.
        do_init(10);
        w0 = wr_cnt;
        for (int k = 0; k < 3; k++) begin
            push_row(10, k, seq_exp(k, 30));
            send_row(seq_row(k, 30));
        end
        t = 0;
        while (wr_cnt != w0 + 13 && t < 50) begin tick(); t++; end
        chk("pre_rst_writes", 32'(wr_cnt - w0), 32'd13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_left", 32'(sb.size()), 32'd2);
        sb.delete();
        w1 = wr_cnt;
        repeat (5) begin
            chk("mid_rst_complete", 32'(bus.complete), 32'd0);
            tick();
        end
        chk("mid_rst_no_writes", 32'(wr_cnt - w1), 32'd0);
        do_init(10);
        run_rows(10, 30, 0);

        // init during WRITE of row 1 is ignored.
        do_init(20);
        push_row(20, 0, seq_exp(0, 50));
        send_row(seq_row(0, 50));
        push_row(20, 1, seq_exp(1, 50));
        send_row(seq_row(1, 50));
        bus.base_address_C = 8'h99;
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        bus.base_address_C = 8'd20;
        for (int k = 2; k < N; k++) begin
            push_row(20, k, seq_exp(k, 50));
            send_row(seq_row(k, 50));
        end
        wait_done();

        // init in DONE restarts; complete drops the following cycle.
        do_init(200);
        chk("done_restart_complete", 32'(bus.complete), 32'd0);
        chk("done_restart_ready", 32'(bus.res_ready), 32'd1);
        run_rows(200, 70, 0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sa_result_drain.md
SA_RESULT_DRAIN -- requirements
Module: sa_result_drain

Interface
REQ-001 Parameter N, default 5, systolic array dimension (rows/columns of the C matrix).
REQ-002 Parameter ACC_W, default 16, width of one signed PE accumulator.
REQ-003 Parameter DW, default 8, memory data word width.
REQ-004 Parameter AW, default 8, memory address width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 init  input  1  one-cycle start pulse for one full C-matrix drain.
REQ-008 base_address_C  input  AW  address of C[0][0] in memory.
REQ-009 res_valid  input  1  array presents one result row on res_data.
REQ-010 res_data  input  N*ACC_W  row accumulators, element j at bits [j*ACC_W +: ACC_W].
REQ-011 res_ready  output  1  block can accept a row this cycle.
REQ-012 mem_we  output  1  memory write strobe, one word per cycle.
REQ-013 mem_addr  output  AW  write address.
REQ-014 mem_wdata  output  DW  write data.
REQ-015 complete  output  1  all N*N words of C written.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_ROW, WRITE, DONE.
REQ-017 IDLE: init=1 latches base_address_C, clears row counter and complete, goes to WAIT_ROW next cycle.
REQ-018 WAIT_ROW: res_ready=1; res_valid=1 captures res_data into an N-entry row buffer, goes to WRITE; res_valid=0 holds state.
REQ-019 res_ready SHALL be 0 in every state except WAIT_ROW; res_valid with res_ready=0 is ignored, no capture.
REQ-020 WRITE: N consecutive cycles with mem_we=1, column j=0..N-1 ascending, mem_addr = base + row*N + j, modulo 2^AW (wraps past 255 to 0).
REQ-021 Latency: row captured at edge k produces first mem_we in cycle k+1, last in cycle k+N, no gaps.
REQ-022 After column N-1: row increments; row<N returns to WAIT_ROW, row=N goes to DONE.
REQ-023 DONE: complete=1, held until next init; init in DONE behaves as in IDLE (restart, complete drops the following cycle).
REQ-024 init in WAIT_ROW or WRITE SHALL be ignored; drain in progress continues unaltered.
REQ-025 mem_addr and mem_wdata SHALL be 0 whenever mem_we=0.
REQ-026 Full drain of one matrix: exactly N*N writes, each address written once, row-major order.

Reset
REQ-027 rst=1 at an edge: state IDLE, row/column counters 0, row buffer 0, latched base 0, res_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, complete=0.
REQ-028 rst overrides init and res_valid in the same cycle.
REQ-029 rst mid-WRITE: no further mem_we from the cycle after the reset edge; partial writes are not undone.

Configuration
REQ-030 Macro SA_DRAIN_SATURATE_EN defined: each signed ACC_W accumulator clamped to [-2^(DW-1), 2^(DW-1)-1] before write (default 8-bit: -128..127).
REQ-031 SA_DRAIN_SATURATE_EN undefined: mem_wdata = accumulator bits [DW-1:0], plain truncation.

Verification
REQ-032 Reset, init with base_address_C=50, 5 rows of values r*5+j+1 at 1 row per 7 cycles -> 25 writes addr 50..74 data 1..25, complete=1 after last write.
REQ-033 res_valid held 1 continuously -> res_ready high exactly 1 cycle per row, each row captured once, 25 writes, no duplicates.
REQ-034 base_address_C=250 -> addresses 250..255 then 0..18, complete after 25th write.
REQ-035 Accumulators 300, -200, 127, -128, 0x0105 -> with SA_DRAIN_SATURATE_EN: 127, -128(0x80), 127, 0x80, 127; without: 0x2C, 0x38, 0x7F, 0x80, 0x05.
REQ-036 rst asserted after 3rd write of row 2 -> mem_we low from next cycle, complete stays 0; new init then drains full 25 words.
REQ-037 init pulsed during WRITE of row 1 -> ignored, address sequence unbroken; init in DONE -> complete drops next cycle, new drain starts.
